input_sync_bank: RTL and testbench
==================================

# input_sync_bank

Parametrised multi-channel input synchroniser with optional per-channel debounce filter and edge-pulse outputs. It is the generalised successor to the fixed two-channel, three-stage synchroniser. Every asynchronous pin entering the BNN core (pixel and weight serial lines, start/mode buttons) passes through it before any FSM samples it. Channel count, synchroniser depth and glitch-filter length are set per instance.

## Interface
- N_CH, default 2: number of independent channels, ≥1.
- STAGES, default 3: synchroniser flop depth per channel, ≥2; fewer is an elaboration error.
- FILT_LEN, default 0: debounce length in cycles. 0 means bypass, no filter registers.
- RESET_VAL, default 1'b0: reset value of all stage, filter and output flops for every channel.
- clk  input  1  single design clock.
- reset_n  input  1  asynchronous, active-low reset.
- async_in  input  N_CH  asynchronous inputs; bit i is channel i.
- sync_out  output  N_CH  synchronised and, if enabled, filtered level.
- rise_pulse  output  N_CH  one-cycle high when sync_out[i] goes 0→1.
- fall_pulse  output  N_CH  one-cycle high when sync_out[i] goes 1→0.
- any_change  output  1  OR of all rise_pulse and fall_pulse bits.

## Operation
- Per channel, a shift chain s[0..STAGES-1] samples async_in[i] every clk edge. raw = s[STAGES-1].
- With FILT_LEN=0, sync_out = raw.
- With FILT_LEN=L>0, each channel has a filtered flop filt and a counter cnt of width clog2(L+1):
  - If raw == filt: cnt <= 0.
  - If raw != filt and cnt < L-1: cnt <= cnt+1.
  - If raw != filt and cnt == L-1: filt <= raw and cnt <= 0.
  - sync_out = filt.
  - Any raw excursion shorter than L cycles is fully suppressed; cnt restarts from 0 on every return to agreement.
- Edge detect: a prev flop holds the previous sync_out. rise = sync_out & ~prev; fall = ~sync_out & prev.
- All outputs are decoded from flops only. There is no combinational path from async_in to any output.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses, and any_change is high for that one cycle.
- Reset asserted at any time, including with data mid-chain, asynchronously forces all s, filt, prev to RESET_VAL and cnt to 0.
  - Result: sync_out = RESET_VAL, rise_pulse = fall_pulse = any_change = 0.
  - After release the chain refills normally.
  - No spurious edge pulse is generated at release unless the input differs from RESET_VAL, in which case exactly one legitimate pulse follows when sync_out changes.

## Timing
- Input set before edge 1 and held: with FILT_LEN=0, sync_out reflects it after edge STAGES.
- With FILT_LEN=L, sync_out reflects it after edge STAGES+L.
- rise_pulse and fall_pulse are high for exactly the first cycle in which sync_out holds its new value.
- Minimum pulse width passed with FILT_LEN=L: L cycles of stable raw.
- With FILT_LEN=0, any input stable for one full cycle propagates as a one-cycle output.
- Throughput: one sample per channel per cycle. No back-pressure, no handshake.

## Structure
- Shared package sync_pkg holds:
  - SYNC_STAGES_MIN = 2.
  - A cnt_width(L) function returning clog2(L+1), minimum 1.
- Sub-module sync_chan implements one channel: chain, optional filter (generate on FILT_LEN), edge detect.
- input_sync_bank generates N_CH instances of sync_chan and ORs the pulses into any_change.

## Test plan
- Reset: inputs = 2'b11 for 5 cycles, then reset_n = 0. Required: sync_out = 00, pulses = 0 immediately, held 00 while in reset. After release with inputs 11, sync_out = 11 at edge 3 and rise_pulse = 11 for one cycle.
- Latency with defaults: async_in = 2'b01 after reset. Required: sync_out = 00 after edges 1 and 2, 01 after edge 3. rise_pulse[0] = 1 for one cycle, any_change = 1 that cycle only.
- Mid-chain reset: inputs 11, wait 2 edges, pulse reset_n low for 1 cycle. Required: sync_out = 00 during reset, 11 exactly 3 edges after release, no pulse before then.
- Filter, N_CH=1, FILT_LEN=4: a 3-cycle high glitch leaves sync_out = 0 with no pulses. A 4-cycle-wide stable high gives sync_out = 1 at edge STAGES+4 after the input change and one rise_pulse.
- Toggle stress, N_CH=4, FILT_LEN=0: invert all inputs every edge for 10 cycles. Required: every sync_out change is accompanied by exactly one matching rise or fall pulse, and the final sync_out equals the last input after 3 edges.
- Independence: toggle channel 0 only while channel 1 is held at 1. Required: sync_out[1] stays 1, with no pulses on channel 1.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the input synchroniser bank and its channels.
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  // Counter width able to hold 0..len, never narrower than one bit.
  function automatic int cnt_width(input int len);
    int w;
    w = $clog2(len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_chan.sv
// One synchroniser channel: metastability chain, optional debounce filter and
// registered-level edge detection.
module sync_chan
  import sync_pkg::*;
#(
  parameter int   STAGES    = 3,
  parameter int   FILT_LEN  = 0,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;
  logic              w_raw;
  logic              w_level;

  if (STAGES < SYNC_STAGES_MIN) begin : g_stage_check
    $error("sync_chan: STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign w_raw = r_chain[STAGES-1];

  // A disagreement must persist FILT_LEN consecutive cycles before the level moves.
  if (FILT_LEN > 0) begin : g_filter
    localparam int            CW   = cnt_width(FILT_LEN);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_filt <= RESET_VAL;
        r_cnt  <= '0;
      end else if (w_raw == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_filt <= w_raw;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign w_level = r_filt;
  end else begin : g_bypass
    assign w_level = w_raw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= RESET_VAL;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/input_sync_bank.sv
// Bank of independent input synchronisers; any_change flags an edge on any channel.
module input_sync_bank
  import sync_pkg::*;
#(
  parameter int   N_CH      = 2,
  parameter int   STAGES    = 3,
  parameter int   FILT_LEN  = 0,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] async_in,
  output logic [N_CH-1:0] sync_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            any_change
);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    sync_chan #(
      .STAGES    (STAGES),
      .FILT_LEN  (FILT_LEN),
      .RESET_VAL (RESET_VAL)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .i_async (async_in[g]),
      .o_level (sync_out[g]),
      .o_rise  (rise_pulse[g]),
      .o_fall  (fall_pulse[g])
    );
  end

  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_input_sync_bank.sv
// Directed bench for input_sync_bank: default 2-channel bank, a filtered
// single-channel bank and an unfiltered 4-channel bank sharing clock and reset.
module tb_input_sync_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [1:0] in2, out2, rise2, fall2;
  logic       any2;
  logic       inF, outF, riseF, fallF, anyF;
  logic [3:0] in4, out4, rise4, fall4;
  logic       any4;

  int checks   = 0;
  int failures = 0;

  input_sync_bank dut2 (
    .clk(clk), .reset_n(reset_n), .async_in(in2),
    .sync_out(out2), .rise_pulse(rise2), .fall_pulse(fall2), .any_change(any2)
  );

  input_sync_bank #(.N_CH(1), .FILT_LEN(4)) dutF (
    .clk(clk), .reset_n(reset_n), .async_in(inF),
    .sync_out(outF), .rise_pulse(riseF), .fall_pulse(fallF), .any_change(anyF)
  );

  input_sync_bank #(.N_CH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .async_in(in4),
    .sync_out(out4), .rise_pulse(rise4), .fall_pulse(fall4), .any_change(any4)
  );

  typedef struct {
    logic [1:0] stim;
    logic [1:0] expOut;
    logic [1:0] expRise;
    logic [1:0] expFall;
    logic       expAny;
  } vec_t;

  vec_t vecs[21];

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] stim);
    in2 = stim;
    tick();
  endtask

  initial begin
    logic [3:0] vals [0:13];
    logic [3:0] exp4, prev4, expR4, expF4;
    logic [2:0] expF;
    int         rise0Count;

    // Three-edge latency table, starting from a settled all-zero bank.
    vecs[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[2]  = '{2'b01, 2'b01, 2'b01, 2'b00, 1'b1};
    vecs[3]  = '{2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    vecs[4]  = '{2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
    vecs[5]  = '{2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
    vecs[6]  = '{2'b00, 2'b00, 2'b00, 2'b01, 1'b1};
    vecs[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[8]  = '{2'b10, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[9]  = '{2'b10, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[10] = '{2'b01, 2'b10, 2'b10, 2'b00, 1'b1};
    vecs[11] = '{2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
    vecs[12] = '{2'b01, 2'b01, 2'b01, 2'b10, 1'b1};
    vecs[13] = '{2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    vecs[14] = '{2'b11, 2'b01, 2'b00, 2'b00, 1'b0};
    vecs[15] = '{2'b11, 2'b01, 2'b00, 2'b00, 1'b0};
    vecs[16] = '{2'b11, 2'b11, 2'b10, 2'b00, 1'b1};
    vecs[17] = '{2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
    vecs[18] = '{2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
    vecs[19] = '{2'b00, 2'b00, 2'b00, 2'b11, 1'b1};
    vecs[20] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0};

    reset_n = 1'b0;
    in2 = 2'b00;
    inF = 1'b0;
    in4 = 4'b0000;
    repeat (3) tick();
    checkOutput("reset_out2", out2, 2'b00);
    checkOutput("reset_pulses2", {rise2, fall2}, 4'b0000);
    checkOutput("reset_any2", any2, 1'b0);
    checkOutput("reset_outF", outF, 1'b0);
    checkOutput("reset_out4", out4, 4'b0000);
    reset_n = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d_out", i), out2, vecs[i].expOut);
      checkOutput($sformatf("vec%0d_rise", i), rise2, vecs[i].expRise);
      checkOutput($sformatf("vec%0d_fall", i), fall2, vecs[i].expFall);
      checkOutput($sformatf("vec%0d_any", i), any2, vecs[i].expAny);
    end

    // Reset asserted with a settled high level, then released with inputs high.
    in2 = 2'b11;
    repeat (5) tick();
    checkOutput("prereset_out", out2, 2'b11);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_out", out2, 2'b00);
    checkOutput("async_reset_pulses", {rise2, fall2, 1'b0, any2}, 4'b0000);
    repeat (2) begin
      tick();
      checkOutput("held_reset_out", out2, 2'b00);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("release_out_e%0d", k), out2, (k >= 3) ? 2'b11 : 2'b00);
      checkOutput($sformatf("release_rise_e%0d", k), rise2, (k == 3) ? 2'b11 : 2'b00);
      checkOutput($sformatf("release_any_e%0d", k), any2, (k == 3) ? 1'b1 : 1'b0);
    end

    // Mid-chain reset: data two stages deep is discarded and the chain refills.
    in2 = 2'b00;
    repeat (4) tick();
    checkOutput("midchain_start", out2, 2'b00);
    in2 = 2'b11;
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    checkOutput("midchain_in_reset", out2, 2'b00);
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("midchain_out_e%0d", k), out2, (k == 3) ? 2'b11 : 2'b00);
      checkOutput($sformatf("midchain_rise_e%0d", k), rise2, (k == 3) ? 2'b11 : 2'b00);
      checkOutput($sformatf("midchain_fall_e%0d", k), fall2, 2'b00);
    end
    // Reset landing on a live pulse must clear it at once.
    reset_n = 1'b0;
    #1;
    checkOutput("reset_kills_pulse", {rise2, 1'b0, any2}, 4'b0000);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();

    // Filtered channel: three-cycle glitch is swallowed entirely.
    for (int k = 1; k <= 13; k++) begin
      inF = (k <= 3);
      tick();
      checkOutput($sformatf("glitch_e%0d", k), {outF, riseF, fallF, anyF}, 4'b0000);
    end

    // Filtered channel: a four-cycle pulse is the shortest one that passes.
    for (int k = 1; k <= 16; k++) begin
      inF = (k <= 4);
      tick();
      expF = {(k >= 7 && k <= 10), (k == 7), (k == 11)};
      checkOutput($sformatf("filt_e%0d", k), {outF, riseF, fallF}, expF);
      checkOutput($sformatf("filt_any_e%0d", k), anyF, |expF[1:0]);
    end

    // Toggle stress on four unfiltered channels.
    vals[0] = 4'b0000;
    vals[1] = 4'b1010;
    for (int k = 2; k <= 10; k++) vals[k] = ~vals[k-1];
    for (int k = 11; k <= 13; k++) vals[k] = vals[10];
    prev4 = 4'b0000;
    for (int k = 1; k <= 13; k++) begin
      in4 = vals[k];
      tick();
      exp4  = (k >= 3) ? vals[k-2] : 4'b0000;
      expR4 = exp4 & ~prev4;
      expF4 = ~exp4 & prev4;
      checkOutput($sformatf("toggle_out_e%0d", k), out4, exp4);
      checkOutput($sformatf("toggle_rise_e%0d", k), rise4, expR4);
      checkOutput($sformatf("toggle_fall_e%0d", k), fall4, expF4);
      checkOutput($sformatf("toggle_any_e%0d", k), any4, |(expR4 | expF4));
      prev4 = exp4;
    end
    checkOutput("toggle_final", out4, vals[10]);

    // Channel independence: channel 1 held high while channel 0 toggles.
    in2 = 2'b10;
    repeat (4) tick();
    checkOutput("indep_start", out2, 2'b10);
    rise0Count = 0;
    for (int k = 1; k <= 12; k++) begin
      in2 = {1'b1, 1'((k / 2) % 2)};
      tick();
      checkOutput($sformatf("indep_ch1_e%0d", k), {out2[1], rise2[1], fall2[1]}, 3'b100);
      if (rise2[0]) rise0Count++;
    end
    checkOutput("indep_ch0_rises", 4'(rise0Count), 4'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
